// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of a dual-clock FIFO: binary/Gray write pointer, memory
// write strobe and address, and full / almost-full / level from the synchronized read pointer.
module async_fifo_wr_ctrl #(
    parameter int ASIZE = 4
) (
    input  logic             wr_clk,
    input  logic             wr_rst_n,
    input  logic             wr_en,
    output logic             wr_full,
    output logic             wr_afull,
    input  logic [ASIZE:0]   wr_afull_thresh,
    output logic [ASIZE:0]   wr_level,
    output logic             wr_overflow,
    input  logic             wr_ovf_clr,
    output logic             mem_wen,
    output logic [ASIZE-1:0] mem_waddr,
    output logic [ASIZE:0]   wr_ptr_gray,
    input  logic [ASIZE:0]   rd_ptr_gray_sync
);

    logic [ASIZE:0] wbin_reg;
    logic [ASIZE:0] wbin_next;
    logic [ASIZE:0] gray_reg;
    logic [ASIZE:0] gray_next;
    logic [ASIZE:0] level_reg;
    logic [ASIZE:0] level_next;
    logic [ASIZE:0] rbin;
    logic [ASIZE:0] full_cmp;
    logic           full_reg;
    logic           full_next;
    logic           afull_reg;
    logic           afull_next;
    logic           ovf_reg;
    logic           ovf_next;
    logic           push;

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    generate
        for (genvar gi = 0; gi <= ASIZE; gi++) begin : g_rbin
            assign rbin[gi] = ^rd_ptr_gray_sync[ASIZE:gi];
        end
    endgenerate

    // Gray code of a pointer exactly one lap ahead of the read pointer.
    assign full_cmp = {~rd_ptr_gray_sync[ASIZE], ~rd_ptr_gray_sync[ASIZE-1],
                       rd_ptr_gray_sync[ASIZE-2:0]};

    // Reset gating keeps the strobe quiet while the pointers are held at zero.
    assign push = wr_en & ~full_reg & wr_rst_n;

    always_comb begin
        wbin_next  = wbin_reg + {{ASIZE{1'b0}}, push};
        gray_next  = wbin_next ^ (wbin_next >> 1);
        level_next = wbin_next - rbin;
        full_next  = (gray_next == full_cmp);
        afull_next = (level_next >= wr_afull_thresh);
        ovf_next   = ovf_reg;
        if (wr_en & full_reg) begin
            ovf_next = 1'b1;
        end else if (wr_ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wbin_reg  <= '0;
            gray_reg  <= '0;
            level_reg <= '0;
            full_reg  <= 1'b0;
            afull_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            wbin_reg  <= wbin_next;
            gray_reg  <= gray_next;
            level_reg <= level_next;
            full_reg  <= full_next;
            afull_reg <= afull_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign mem_wen     = push;
    assign mem_waddr   = wbin_reg[ASIZE-1:0];
    assign wr_ptr_gray = gray_reg;
    assign wr_full     = full_reg;
    assign wr_afull    = afull_reg;
    assign wr_level    = level_reg;
    assign wr_overflow = ovf_reg;

endmodule
